// File: rtl/neuron_pkg.sv
// ============================================================================
// Module   : neuron_pkg
// Purpose  : Shared widths, FSM states and saturation limits for the neuron
//            multiply-accumulate stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package neuron_pkg;

  localparam int DATA_W            = 16;
  localparam int FRAC_BITS_DEFAULT = 12;
  localparam int MAX_LEN_DEFAULT   = 256;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  // Product is 32 bits; enough headroom on top to sum MAX_LEN of them.
  function automatic int acc_w(input int max_len);
    return 32 + $clog2(max_len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/neuron_accumulate_if.sv
// ============================================================================
// Module   : neuron_accumulate_if
// Purpose  : Beat input and result output bundle of neuron_accumulate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface neuron_accumulate_if;
  import neuron_pkg::*;

  logic                     valid_in;
  logic                     last_in;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] w_in;
  logic signed [DATA_W-1:0] bias_in;
  logic                     valid_out;
  logic        [DATA_W-1:0] data_out;
  logic                     sat_out;
  logic                     len_err_out;

  modport master (
    output valid_in, last_in, x_in, w_in, bias_in,
    input  valid_out, data_out, sat_out, len_err_out
  );

  modport slave (
    input  valid_in, last_in, x_in, w_in, bias_in,
    output valid_out, data_out, sat_out, len_err_out
  );

endinterface

`default_nettype wire

// File: rtl/neuron_accumulate_round_sat.sv
// ============================================================================
// Module   : round_sat
// Purpose  : Combinational round-half-up of an accumulator to Q3.12 with
//            clamping to the signed 16-bit range and a saturation flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_sat
  import neuron_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT,
  parameter int ACC_W     = 40
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] data,
  output logic              sat
);

  localparam logic [ACC_W-1:0] c_half = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] c_hi =
    {{(ACC_W-DATA_W){SAT_MAX[DATA_W-1]}}, SAT_MAX};
  localparam logic signed [ACC_W-1:0] c_lo =
    {{(ACC_W-DATA_W){SAT_MIN[DATA_W-1]}}, SAT_MIN};

  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_r;

  // Adding half an LSB then flooring sends exact ties toward +inf.
  assign w_sum = acc + c_half;
  assign w_r   = w_sum >>> FRAC_BITS;

  always_comb begin
    data = w_r[DATA_W-1:0];
    sat  = 1'b0;
    if (w_r > c_hi) begin
      data = SAT_MAX;
      sat  = 1'b1;
    end else if (w_r < c_lo) begin
      data = SAT_MIN;
      sat  = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/neuron_accumulate.sv
// ============================================================================
// Module   : neuron_accumulate
// Purpose  : Streaming multiply-accumulate of (x, w) beats plus bias, rounded
//            and saturated to Q3.12 for the downstream sigmoid stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module neuron_accumulate
  import neuron_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT,
  parameter int MAX_LEN   = MAX_LEN_DEFAULT,
  parameter int ACC_W     = acc_w(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  neuron_accumulate_if.slave bus
);

  localparam int c_cnt_w = $clog2(MAX_LEN + 2);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_LEN);
  localparam logic [c_cnt_w-1:0] c_cnt_sat = c_cnt_w'(MAX_LEN + 1);

  // Stage 1: FSM and product register
  state_t              r_state;
  logic                r_s1_valid;
  logic                r_s1_first;
  logic                r_s1_last;
  logic [31:0]         r_s1_prod;
  logic [DATA_W-1:0]   r_s1_bias;

  logic [31:0]         w_x_ext;
  logic [31:0]         w_w_ext;
  logic [31:0]         w_prod;

  assign w_x_ext = {{(32-DATA_W){bus.x_in[DATA_W-1]}}, bus.x_in};
  assign w_w_ext = {{(32-DATA_W){bus.w_in[DATA_W-1]}}, bus.w_in};
  assign w_prod  = w_x_ext * w_w_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_bias  <= '0;
    end else begin
      r_s1_valid <= bus.valid_in;
      if (bus.valid_in) begin
        r_s1_first <= (r_state == S_IDLE);
        r_s1_last  <= bus.last_in;
        r_s1_prod  <= w_prod;
        r_s1_bias  <= bus.bias_in;
        case (r_state)
          S_IDLE:  if (!bus.last_in) r_state <= S_ACCUM;
          S_ACCUM: if (bus.last_in)  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Stage 2: accumulator and beat counter
  logic [ACC_W-1:0]    r_acc;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_s2_last;
  logic                r_s2_len_err;

  logic [ACC_W-1:0]    w_prod_ext;
  logic [ACC_W-1:0]    w_bias_ext;
  logic [ACC_W-1:0]    w_acc_next;
  logic [c_cnt_w-1:0]  w_cnt_next;

  assign w_prod_ext = {{(ACC_W-32){r_s1_prod[31]}}, r_s1_prod};
  assign w_bias_ext = {{(ACC_W-DATA_W-FRAC_BITS){r_s1_bias[DATA_W-1]}},
                       r_s1_bias, {FRAC_BITS{1'b0}}};
  assign w_acc_next = (r_s1_first ? w_bias_ext : r_acc) + w_prod_ext;
  assign w_cnt_next = r_s1_first           ? c_cnt_w'(1) :
                      (r_cnt == c_cnt_sat) ? r_cnt       :
                                             r_cnt + c_cnt_w'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_s2_last    <= 1'b0;
      r_s2_len_err <= 1'b0;
    end else begin
      r_s2_last <= r_s1_valid & r_s1_last;
      if (r_s1_valid) begin
        r_acc        <= w_acc_next;
        r_cnt        <= w_cnt_next;
        r_s2_len_err <= (w_cnt_next > c_cnt_max);
      end
    end
  end

  // Snapshot of a finished sum, so a following first beat can reload r_acc
  // in the same cycle without corrupting the result on its way out.
  logic [ACC_W-1:0]    r_hold_acc;
  logic                r_hold_valid;
  logic                r_hold_len_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_acc     <= '0;
      r_hold_valid   <= 1'b0;
      r_hold_len_err <= 1'b0;
    end else begin
      r_hold_valid <= r_s2_last;
      if (r_s2_last) begin
        r_hold_acc     <= r_acc;
        r_hold_len_err <= r_s2_len_err;
      end
    end
  end

  // Stage 3: round, clamp and register the result
  logic [DATA_W-1:0]   w_rs_data;
  logic                w_rs_sat;
  logic                r_valid_out;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_sat_out;
  logic                r_len_err_out;

  round_sat #(
    .FRAC_BITS (FRAC_BITS),
    .ACC_W     (ACC_W)
  ) u_round_sat (
    .acc  (r_hold_acc),
    .data (w_rs_data),
    .sat  (w_rs_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid_out   <= 1'b0;
      r_data_out    <= '0;
      r_sat_out     <= 1'b0;
      r_len_err_out <= 1'b0;
    end else begin
      r_valid_out <= r_hold_valid;
      if (r_hold_valid) begin
        r_data_out    <= w_rs_data;
        r_sat_out     <= w_rs_sat;
        r_len_err_out <= r_hold_len_err;
      end
    end
  end

  assign bus.valid_out   = r_valid_out;
  assign bus.data_out    = r_data_out;
  assign bus.sat_out     = r_sat_out;
  assign bus.len_err_out = r_len_err_out;

endmodule

`default_nettype wire

// File: tb/tb_neuron_accumulate.sv
// ============================================================================
// Module   : tb_neuron_accumulate
// Purpose  : Self-checking bench for neuron_accumulate against an arithmetic
//            reference of the pre-activation, rounding and clamping rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neuron_accumulate;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_accumulate_if bus();

  neuron_accumulate dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        s;
    logic        l;
    logic [31:0] c;
  } res_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  res_t exp_q[$];
  res_t obs_q[$];
  logic [15:0] vx [0:511];
  logic [15:0] vw [0:511];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.valid_out === 1'b1)
      obs_q.push_back({bus.data_out, bus.sat_out, bus.len_err_out, 32'(cyc)});

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
      bus.last_in  = 1'b0;
    end
  endtask

  // Drives one vector and queues its expected result. force_d/force_s >= 0
  // replace the reference value with a hand-derived constant.
  task automatic send_vec(input int n, input logic [15:0] bias, input int gap_at,
                          input int gap_len, input int force_d, input int force_s);
    longint s;
    longint r;
    int     t;
    res_t   e;
    s = longint'($signed(bias)) * 4096;
    t = 0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) idle(gap_len);
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.last_in  = (i == n - 1);
      bus.x_in     = vx[i];
      bus.w_in     = vw[i];
      bus.bias_in  = (i == 0) ? bias : 16'($urandom);
      s += longint'($signed(vx[i])) * longint'($signed(vw[i]));
      if (i == n - 1) t = cyc + 1;
    end
    r = (s + 2048) >>> 12;
    if (r > 32767)       begin e.d = 16'h7FFF; e.s = 1'b1; end
    else if (r < -32768) begin e.d = 16'h8000; e.s = 1'b1; end
    else                 begin e.d = 16'(r);   e.s = 1'b0; end
    if (force_d >= 0) e.d = 16'(force_d);
    if (force_s >= 0) e.s = force_s[0];
    e.l = (n > 256);
    e.c = 32'(t + 3);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    bus.valid_in = 1'b0; bus.last_in = 1'b0;
    bus.x_in = '0; bus.w_in = '0; bus.bias_in = '0;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.valid_out !== 1'b0 || bus.data_out !== 16'h0000 ||
          bus.sat_out !== 1'b0 || bus.len_err_out !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs: got v=%b d=%h s=%b l=%b, required v=0 d=0000 s=0 l=0",
                 bus.valid_out, bus.data_out, bus.sat_out, bus.len_err_out);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    res_t e, o, last_e;
    last_e = '0;
    vx[0] = 16'h1000; vw[0] = 16'h1000;
    send_vec(1, 16'h0000, -1, 0, 'h1000, 0);
    for (int i = 0; i < 4; i++) begin vx[i] = 16'h7FFF; vw[i] = 16'h7FFF; end
    send_vec(4, 16'h7FFF, -1, 0, 'h7FFF, 1);
    for (int i = 0; i < 4; i++) vw[i] = 16'h8001;
    send_vec(4, 16'h7FFF, -1, 0, 'h8000, 1);
    vx[0] = 16'h0001; vw[0] = 16'h0800;
    send_vec(1, 16'h0000, -1, 0, 'h0001, 0);
    vx[0] = 16'hFFFF; vw[0] = 16'h0800;
    send_vec(1, 16'h0000, -1, 0, 'h0000, 0);
    vx[0] = 16'hFFFF; vw[0] = 16'h0C00;
    send_vec(1, 16'h0000, -1, 0, 'hFFFF, 0);
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_e = e;
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL directed_missing: got no result, required d=%h at cyc %0d", e.d, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL directed_result: got d=%h s=%b l=%b cyc=%0d, required d=%h s=%b l=%b cyc=%0d",
                   o.d, o.s, o.l, o.c, e.d, e.s, e.l, e.c);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL directed_extra: got %0d extra results, required 0", obs_q.size());
    end
    obs_q.delete();
    checks++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== last_e.d || bus.sat_out !== last_e.s) begin
      failures++;
      $display("FAIL directed_hold: got v=%b d=%h s=%b, required v=0 d=%h s=%b",
               bus.valid_out, bus.data_out, bus.sat_out, last_e.d, last_e.s);
    end
  endtask

  task automatic test_back_to_back();
    res_t e, o;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin vx[i] = 16'h1000; vw[i] = 16'h0800; end
      send_vec(3, 16'h0100, (k == 0) ? 2 : -1, 2, 'h1900, 0);
      vx[0] = 16'h2000; vw[0] = 16'h1000;
      send_vec(1, 16'hF000, -1, 0, 'h1000, 0);
    end
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL b2b_missing: got no result, required d=%h at cyc %0d", e.d, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL b2b_result: got d=%h s=%b l=%b cyc=%0d, required d=%h s=%b l=%b cyc=%0d",
                   o.d, o.s, o.l, o.c, e.d, e.s, e.l, e.c);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_extra: got %0d extra results, required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    res_t e, o;
    repeat (2) begin
      @(negedge clk);
      bus.valid_in = 1'b1; bus.last_in = 1'b0;
      bus.x_in = 16'h1000; bus.w_in = 16'h1000; bus.bias_in = 16'h0400;
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (bus.data_out !== 16'h0000 || bus.valid_out !== 1'b0) begin
      failures++;
      $display("FAIL midreset_clear: got v=%b d=%h, required v=0 d=0000", bus.valid_out, bus.data_out);
    end
    vx[0] = 16'h1000; vw[0] = 16'h1000;
    send_vec(1, 16'h0000, -1, 0, 'h1000, 0);
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL midreset_missing: got no result, required d=%h at cyc %0d", e.d, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL midreset_result: got d=%h s=%b l=%b cyc=%0d, required d=%h s=%b l=%b cyc=%0d",
                   o.d, o.s, o.l, o.c, e.d, e.s, e.l, e.c);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_extra: got %0d extra results, required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_len_err();
    res_t e, o;
    for (int i = 0; i < 257; i++) begin vx[i] = 16'h0000; vw[i] = 16'h0000; end
    send_vec(257, 16'h0000, -1, 0, -1, -1);
    send_vec(256, 16'h0000, 100, 3, -1, -1);
    send_vec(257, 16'h0000, 200, 1, -1, -1);
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL len_err_missing: got no result, required l=%b at cyc %0d", e.l, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL len_err_result: got d=%h s=%b l=%b cyc=%0d, required d=%h s=%b l=%b cyc=%0d",
                   o.d, o.s, o.l, o.c, e.d, e.s, e.l, e.c);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL len_err_extra: got %0d extra results, required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_random();
    res_t e, o;
    int   n;
    for (int v = 0; v < 40; v++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        vx[i] = 16'($urandom);
        vw[i] = 16'($urandom);
      end
      send_vec(n, 16'($urandom), $urandom_range(0, n), $urandom_range(1, 3), -1, -1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL random_missing: got no result, required d=%h at cyc %0d", e.d, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL random_result: got d=%h s=%b l=%b cyc=%0d, required d=%h s=%b l=%b cyc=%0d",
                   o.d, o.s, o.l, o.c, e.d, e.s, e.l, e.c);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL random_extra: got %0d extra results, required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_len_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
